room_draw_datapath: RTL
=======================

Name: room_draw_datapath

Overview:
- VGA drawing datapath directly downstream of the home-simulation control path.
- Consumes the room enables, drawen and clearinitsignal strobes, plus the keyboard (L/D) and audio (ON/OFF) inputs.
- Produces pixel writes (x, y, colour, plot) for the VGA adapter.
- Returns plotcounter, clear_x/clear_y, MAX_X_PIXELS/MAX_Y_PIXELS and countDone, which close the control path's state transitions.
- Keeps a per-room status record: function and on/off for rooms 0-4.

Parameters:
- MAX_X, 159, last valid x pixel (160-wide screen).
- MAX_Y, 119, last valid y pixel.
- ROOM_Y, 40, top row of every room indicator square.
- ROOM_X0, 16, left column of room 0's square.
- ROOM_PITCH, 28, x spacing between adjacent room squares.

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- enable0..enable4  in  1 each  room-n draw select from the control path
- drawen  in  1  draw window qualifier
- clearinitsignal  in  1  full-screen clear request
- keyboardin  in  1  1 = Light, 0 = Door
- audin  in  1  1 = ON/open, 0 = OFF/closed
- plotcounter  out  4  pixel index within the 4x4 room square
- clear_x  out  8  clear sweep column
- clear_y  out  7  clear sweep row
- MAX_X_PIXELS  out  8  constant MAX_X
- MAX_Y_PIXELS  out  7  constant MAX_Y
- x  out  8  pixel column to VGA
- y  out  7  pixel row to VGA
- colour  out  3  RGB pixel colour
- plot  out  1  VGA write strobe
- countDone  out  1  one-cycle pulse when a draw or clear completes
- room_status  out  10  {func,onoff} per room; room n at bits [2n+1:2n]

Behaviour:
- Reset (resetn=0, async): every register clears to 0, FSM goes to S_IDLE.
  - Outputs become plotcounter=0, clear_x=0, clear_y=0, x=0, y=0, colour=0, plot=0, countDone=0, room_status=0.
  - MAX_X_PIXELS/MAX_Y_PIXELS are constants and unaffected.
- Room select: the lowest-indexed asserted enable wins; sel = none when no enable is asserted.
- Priority: clearinitsignal > draw > idle, evaluated every cycle.
- FSM states: S_IDLE, S_DRAW, S_CLEAR, S_DONE.
- S_IDLE:
  - clearinitsignal=1 -> S_CLEAR.
  - Otherwise drawen=1 with sel valid -> S_DRAW.
  - plotcounter, clear_x and clear_y are held at 0.
- S_DRAW, first cycle (plotcounter=0):
  - room_status[sel] latches {keyboardin, audin}.
  - The latched value sets the colour for the whole square.
- S_DRAW, each cycle:
  - plotcounter increments 0..15, one per cycle.
  - Registered outputs next cycle: x = ROOM_X0 + sel*ROOM_PITCH + plotcounter[1:0]; y = ROOM_Y + plotcounter[3:2]; plot = 1.
  - Pixel latency is 1 cycle from plotcounter value to x/y/plot.
- S_DRAW exit:
  - Cycle with plotcounter=15 -> S_DONE, and plotcounter returns to 0.
  - 16 pixels are plotted in total.
- Colour table (func,onoff):
  - L,ON = 3'b110 (yellow).
  - L,OFF = 3'b001 (blue).
  - D,open = 3'b010 (green).
  - D,closed = 3'b100 (red).
- Draw abort:
  - drawen=0 or sel lost mid-draw -> S_IDLE; plotcounter=0 next cycle.
  - No countDone, no further plot; room_status keeps the latched value.
- S_CLEAR, sweep:
  - Each cycle: plot=1 (registered, 1-cycle latency), colour=0, x=clear_x, y=clear_y.
  - clear_x increments; at MAX_X it wraps to 0 and clear_y increments.
- S_CLEAR, end of sweep:
  - At (MAX_X, MAX_Y) the counters hold; that pixel is plotted once and the FSM goes to S_DONE.
  - Counters reset to 0 on entry to S_DONE.
- Clear abort: clearinitsignal drop mid-sweep -> S_IDLE with counters zeroed.
- Clear interrupting a draw: clearinitsignal asserted during S_DRAW -> S_CLEAR next cycle; plotcounter=0.
- S_DONE:
  - countDone=1 for exactly one cycle, plot=0 -> S_IDLE.
  - If clearinitsignal=1 in S_DONE, go to S_CLEAR instead; countDone is still pulsed.
- plot is 0 in S_IDLE and S_DONE, except for the registered final pixel emitted the cycle after the last DRAW/CLEAR cycle.
- Width rules:
  - x computed in 8 bits; the maximum is 16+4*28+3 = 131 < 160, so no overflow.
  - y computed in 7 bits; the maximum is 43.
- Clear does not modify room_status.

Test Plan:
- Reset: resetn=0 mid-draw at plotcounter=7 -> all outputs 0 immediately (async); after release, FSM in S_IDLE, plot=0.
- Room draw: enable2=1, drawen=1, keyboardin=1, audin=1 for 16 cycles.
  - Expect plotcounter 0..15, then 16 plots with x=72..75, y=40..43, colour=3'b110.
  - Expect room_status[5:4]=2'b11 and countDone high for 1 cycle, 2 cycles after plotcounter=15.
- Multiple enables: enable1=1 and enable3=1, keyboardin=0, audin=0.
  - Expect room 1 drawn (x=44..47), colour=3'b100, room_status[3:2]=2'b00, room 3 status unchanged.
- Draw abort: drawen drops at plotcounter=5 -> plotcounter=0 next cycle, no countDone, plot stops after the registered pixel for index 5.
- Clear sweep: clearinitsignal=1 from idle.
  - Expect 19200 consecutive plots with colour=0, clear_x wrapping 159->0 with clear_y incrementing.
  - Expect counters to hold at (159,119), then one countDone pulse, then counters back to 0.
- Clear pre-empts draw: assert clearinitsignal while enable0 draw is at plotcounter=9.
  - Expect S_CLEAR next cycle, plotcounter=0, first clear pixel at (0,0).
  - Expect room_status[1:0] to keep the value latched at draw start.

Source files
------------

// File: rtl/room_draw_datapath_if.sv
// Bus between the home-simulation control path (master) and the room drawing
// datapath (slave): room selects, draw/clear strobes, pixel writes and progress.
interface room_draw_datapath_if;
  logic       enable0, enable1, enable2, enable3, enable4;
  logic       drawen, clearinitsignal, keyboardin, audin;
  logic [3:0] plotcounter;
  logic [7:0] clear_x;
  logic [6:0] clear_y;
  logic [7:0] MAX_X_PIXELS;
  logic [6:0] MAX_Y_PIXELS;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, countDone;
  logic [9:0] room_status;

  modport master (
    output enable0, enable1, enable2, enable3, enable4,
    output drawen, clearinitsignal, keyboardin, audin,
    input  plotcounter, clear_x, clear_y, MAX_X_PIXELS, MAX_Y_PIXELS,
    input  x, y, colour, plot, countDone, room_status
  );

  modport slave (
    input  enable0, enable1, enable2, enable3, enable4,
    input  drawen, clearinitsignal, keyboardin, audin,
    output plotcounter, clear_x, clear_y, MAX_X_PIXELS, MAX_Y_PIXELS,
    output x, y, colour, plot, countDone, room_status
  );
endinterface

// File: rtl/room_draw_datapath.sv
// Draws 4x4 room status squares and full-screen clears for the VGA adapter,
// and keeps the per-room {function, on/off} record.
module room_draw_datapath #(
  parameter int MAX_X      = 159,
  parameter int MAX_Y      = 119,
  parameter int ROOM_Y     = 40,
  parameter int ROOM_X0    = 16,
  parameter int ROOM_PITCH = 28
) (
  input logic clock,
  input logic resetn,
  room_draw_datapath_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CLEAR, S_DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] plotcounter_q, plotcounter_d;
  logic [7:0] clear_x_q, clear_x_d, x_q, x_d;
  logic [6:0] clear_y_q, clear_y_d, y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, count_done_q, count_done_d;
  logic [9:0] room_status_q, room_status_d;
  logic [4:0] enables;
  logic       sel_vld;
  logic [2:0] sel;
  logic [1:0] cur_st;

  function automatic logic [2:0] room_colour(input logic [1:0] st);
    unique case (st)
      2'b11:   return 3'b110;
      2'b10:   return 3'b001;
      2'b01:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  assign enables = {bus.enable4, bus.enable3, bus.enable2, bus.enable1, bus.enable0};
  assign sel_vld = |enables;

  // Downward scan so the lowest-indexed asserted enable is the last write.
  always_comb begin
    sel = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (enables[i]) sel = 3'(i);
  end

  always_comb begin
    state_d       = state_q;
    plotcounter_d = plotcounter_q;
    clear_x_d     = clear_x_q;
    clear_y_d     = clear_y_q;
    x_d           = x_q;
    y_d           = y_q;
    colour_d      = colour_q;
    plot_d        = 1'b0;
    count_done_d  = (state_q == S_DONE);
    room_status_d = room_status_q;
    cur_st        = 2'b00;
    for (int i = 0; i < 5; i++)
      if (sel == 3'(i)) cur_st = room_status_q[2*i +: 2];

    unique case (state_q)
      S_IDLE: begin
        plotcounter_d = '0;
        clear_x_d     = '0;
        clear_y_d     = '0;
        if (bus.clearinitsignal)         state_d = S_CLEAR;
        else if (bus.drawen && sel_vld)  state_d = S_DRAW;
      end
      S_DRAW: begin
        if (bus.clearinitsignal) begin
          state_d       = S_CLEAR;
          plotcounter_d = '0;
        end else begin
          // The pixel for the current index is emitted whenever a room is
          // selected; drawen only decides whether the sweep carries on.
          if (sel_vld) begin
            if (plotcounter_q == 4'd0) begin
              cur_st = {bus.keyboardin, bus.audin};
              for (int i = 0; i < 5; i++)
                if (sel == 3'(i)) room_status_d[2*i +: 2] = cur_st;
            end
            x_d      = 8'(ROOM_X0 + ROOM_PITCH * int'(sel) + int'(plotcounter_q[1:0]));
            y_d      = 7'(ROOM_Y + int'(plotcounter_q[3:2]));
            colour_d = room_colour(cur_st);
            plot_d   = 1'b1;
          end
          if (!(bus.drawen && sel_vld)) begin
            state_d       = S_IDLE;
            plotcounter_d = '0;
          end else begin
            plotcounter_d = plotcounter_q + 4'd1;
            if (plotcounter_q == 4'd15) state_d = S_DONE;
          end
        end
      end
      S_CLEAR: begin
        if (!bus.clearinitsignal) begin
          state_d   = S_IDLE;
          clear_x_d = '0;
          clear_y_d = '0;
        end else begin
          x_d      = clear_x_q;
          y_d      = clear_y_q;
          colour_d = 3'b000;
          plot_d   = 1'b1;
          if (clear_x_q == 8'(MAX_X) && clear_y_q == 7'(MAX_Y)) begin
            state_d = S_DONE;
          end else if (clear_x_q == 8'(MAX_X)) begin
            clear_x_d = '0;
            clear_y_d = clear_y_q + 7'd1;
          end else begin
            clear_x_d = clear_x_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        plotcounter_d = '0;
        clear_x_d     = '0;
        clear_y_d     = '0;
        state_d       = bus.clearinitsignal ? S_CLEAR : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      plotcounter_q <= '0;
      clear_x_q     <= '0;
      clear_y_q     <= '0;
      x_q           <= '0;
      y_q           <= '0;
      colour_q      <= '0;
      plot_q        <= 1'b0;
      count_done_q  <= 1'b0;
      room_status_q <= '0;
    end else begin
      state_q       <= state_d;
      plotcounter_q <= plotcounter_d;
      clear_x_q     <= clear_x_d;
      clear_y_q     <= clear_y_d;
      x_q           <= x_d;
      y_q           <= y_d;
      colour_q      <= colour_d;
      plot_q        <= plot_d;
      count_done_q  <= count_done_d;
      room_status_q <= room_status_d;
    end
  end

  assign bus.plotcounter  = plotcounter_q;
  assign bus.clear_x      = clear_x_q;
  assign bus.clear_y      = clear_y_q;
  assign bus.MAX_X_PIXELS = 8'(MAX_X);
  assign bus.MAX_Y_PIXELS = 7'(MAX_Y);
  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.colour       = colour_q;
  assign bus.plot         = plot_q;
  assign bus.countDone    = count_done_q;
  assign bus.room_status  = room_status_q;
endmodule
